// File: rtl/word_packer_pkg.sv
// Shared helpers for the narrow-to-wide word packer.
package packer_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 128;

  // Number of input beats per output word.
  function automatic int ratio_of(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // Counter width able to hold 0..RATIO.
  function automatic int cnt_w_of(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Output lane that beat k of a word lands in.
  function automatic int unsigned lane_of(input int unsigned k,
                                          input int unsigned ratio,
                                          input bit          msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/word_packer_if.sv
// Input beat stream and output word stream of the word packer.
interface word_packer_if
  import packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 128
);
  localparam int RATIO = ratio_of(OUT_W, IN_W);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             flush;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  // Packer side.
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_keep, out_last, out_valid
  );

  // Producer/consumer side.
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/word_packer_out_slot.sv
// Single-entry valid/ready holding register for a closed word; a new word
// may be loaded on the same edge the current one is taken.
module pack_out_slot #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_free,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_last
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic              r_last;

  // Slot can accept a word when empty or being drained this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

  // Load has priority over drain so a drain+load edge leaves no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/word_packer.sv
// Packs RATIO = OUT_W/IN_W input beats into one output word, with flush of
// partial words (lane mask in out_keep) and full backpressure.
module word_packer
  import packer_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 128,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  word_packer_if.slave  bus
);
  localparam int RATIO  = ratio_of(OUT_W, IN_W);
  localparam int CNT_W  = cnt_w_of(RATIO);
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (((OUT_W % IN_W) != 0) || (RATIO < 2)) begin : g_param_check
    $error("word_packer: OUT_W must be a multiple of IN_W with OUT_W/IN_W >= 2");
  end

  logic [CNT_W-1:0]  r_cnt;
  logic [OUT_W-1:0]  r_acc;
  logic [RATIO-1:0]  r_keep;
  logic              r_last;
  logic              r_pend;

  logic              w_in_ready;
  logic              w_fire;
  logic              w_close;
  logic              w_word_rdy;
  logic              w_slot_free;
  logic              w_load;
  logic [LANE_W-1:0] w_lane;
  logic [OUT_W-1:0]  w_acc_nxt;
  logic [RATIO-1:0]  w_keep_nxt;
  logic              w_last_nxt;

  logic              w_out_valid;
  logic [OUT_W-1:0]  w_out_data;
  logic [RATIO-1:0]  w_out_keep;
  logic              w_out_last;

  // A pending word blocks input; no path from out_ready to in_ready.
  assign w_in_ready = !rst && !r_pend;
  assign w_fire     = bus.in_valid && w_in_ready;
  assign w_lane     = LANE_W'(lane_of(32'(r_cnt), RATIO, MSB_FIRST));

  // Accumulator and lane mask as they stand after this cycle's beat.
  always_comb begin
    w_acc_nxt  = r_acc;
    w_keep_nxt = r_keep;
    if (w_fire) begin
      w_acc_nxt[w_lane*IN_W +: IN_W] = bus.in_data;
      w_keep_nxt[w_lane]             = 1'b1;
    end
  end

  // A flush always carries a beat, so it always closes a non-empty word.
  assign w_close    = w_fire && (bus.flush || (r_cnt == CNT_W'(RATIO - 1)));
  assign w_last_nxt = w_fire ? bus.flush : r_last;
  assign w_word_rdy = w_close || r_pend;
  assign w_load     = w_word_rdy && w_slot_free;

  // Accumulator, lane counter and pending-word control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_pend <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_pend <= 1'b0;
    end else if (w_close) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_acc  <= w_acc_nxt;
      r_keep <= w_keep_nxt;
      r_last <= bus.flush;
      r_pend <= 1'b1;
    end else if (w_fire) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_acc  <= w_acc_nxt;
      r_keep <= w_keep_nxt;
    end
  end

  pack_out_slot #(
    .DATA_W (OUT_W),
    .KEEP_W (RATIO)
  ) u_slot (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_data  (w_acc_nxt),
    .i_keep  (w_keep_nxt),
    .i_last  (w_last_nxt),
    .i_ready (bus.out_ready),
    .o_free  (w_slot_free),
    .o_valid (w_out_valid),
    .o_data  (w_out_data),
    .o_keep  (w_out_keep),
    .o_last  (w_out_last)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_keep  = w_out_keep;
  assign bus.out_last  = w_out_last;
endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: directed scenarios plus randomized
// traffic compared against a queue-based word model.
module tb_word_packer;

  logic clk;
  logic rst;

  word_packer_if #(.IN_W(8),  .OUT_W(128)) b0 ();
  word_packer_if #(.IN_W(32), .OUT_W(64))  b1 ();

  word_packer #(.IN_W(8), .OUT_W(128), .MSB_FIRST(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  word_packer #(.IN_W(32), .OUT_W(64), .MSB_FIRST(1'b0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } word_t;

  word_t       exp_q[$];
  logic [7:0]  m_cur[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          n_words  = 0;
  int          n_acc    = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: beat k of a word goes to lane 15-k; unfilled lanes stay zero.
  task automatic model_close(input logic fl);
    word_t w;
    w = '0;
    for (int k = 0; k < m_cur.size(); k++) begin
      w.d[(15-k)*8 +: 8] = m_cur[k];
      w.k[15-k]          = 1'b1;
    end
    w.l = fl;
    exp_q.push_back(w);
    m_cur.delete();
  endtask

  // One clock: settle inputs, observe handshakes for the model, advance.
  task automatic step();
    #1;
    if (rst) begin
      m_cur.delete();
      exp_q.delete();
    end else begin
      if (b0.out_valid && b0.out_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 128'(exp_q.size()), 128'(1));
        end else begin
          chk("word_data", b0.out_data, exp_q[0].d);
          chk("word_keep", 128'(b0.out_keep), 128'(exp_q[0].k));
          chk("word_last", 128'(b0.out_last), 128'(exp_q[0].l));
          void'(exp_q.pop_front());
        end
      end
      if (b0.in_valid && b0.in_ready) begin
        n_acc++;
        m_cur.push_back(b0.in_data);
        if (m_cur.size() == 16 || b0.flush) model_close(b0.flush);
      end
    end
    @(posedge clk);
    #1;
  endtask

  int base_w;
  int base_a;
  int guard;

  initial begin
    rst          = 1'b1;
    b0.in_data   = '0;
    b0.in_valid  = 1'b0;
    b0.flush     = 1'b0;
    b0.out_ready = 1'b0;
    b1.in_data   = '0;
    b1.in_valid  = 1'b0;
    b1.flush     = 1'b0;
    b1.out_ready = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 128'(b0.out_valid), 128'(0));
    chk("rst_out_data",  b0.out_data, 128'(0));
    chk("rst_out_keep",  128'(b0.out_keep), 128'(0));
    chk("rst_out_last",  128'(b0.out_last), 128'(0));
    chk("rst_in_ready",  128'(b0.in_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 128'(b0.in_ready), 128'(1));

    // Full word, MSB lane first, no stall
    b0.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b0.in_valid = 1'b1;
      b0.in_data  = 8'(i);
      #1;
      chk("full_in_ready", 128'(b0.in_ready), 128'(1));
      if (i == 15) chk("full_no_early_valid", 128'(b0.out_valid), 128'(0));
      step();
    end
    b0.in_valid = 1'b0;
    #1;
    chk("full_valid", 128'(b0.out_valid), 128'(1));
    chk("full_data",  b0.out_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("full_keep",  128'(b0.out_keep), 128'hFFFF);
    chk("full_last",  128'(b0.out_last), 128'(0));
    step();
    chk("full_drained", 128'(b0.out_valid), 128'(0));

    // LSB-first 32->64 instance
    b1.in_valid = 1'b1;
    b1.in_data  = 32'hAAAA0001;
    step();
    b1.in_data  = 32'hBBBB0002;
    step();
    b1.in_valid = 1'b0;
    #1;
    chk("lsb_valid", 128'(b1.out_valid), 128'(1));
    chk("lsb_data",  128'(b1.out_data), 128'h0000000000000000BBBB0002AAAA0001);
    chk("lsb_keep",  128'(b1.out_keep), 128'(2'b11));
    step();

    // Flush of a partial word
    b0.in_valid = 1'b1;
    b0.in_data = 8'h11; step();
    b0.in_data = 8'h22; step();
    b0.in_data = 8'h33; b0.flush = 1'b1; step();
    b0.in_valid = 1'b0; b0.flush = 1'b0;
    #1;
    chk("flush_valid", 128'(b0.out_valid), 128'(1));
    chk("flush_data",  b0.out_data, 128'h11223300000000000000000000000000);
    chk("flush_keep",  128'(b0.out_keep), 128'hE000);
    chk("flush_last",  128'(b0.out_last), 128'(1));
    step();
    b0.in_valid = 1'b1; b0.in_data = 8'h44; b0.flush = 1'b1; step();
    b0.in_valid = 1'b0; b0.flush = 1'b0;
    #1;
    chk("flush1_data", b0.out_data, 128'h44000000000000000000000000000000);
    chk("flush1_keep", 128'(b0.out_keep), 128'h8000);
    chk("flush1_last", 128'(b0.out_last), 128'(1));
    step();

    // Backpressure with 48 beats offered
    b0.out_ready = 1'b0;
    base_a = n_acc;
    base_w = n_words;
    for (int c = 0; c < 40; c++) begin
      b0.in_valid = (n_acc - base_a) < 48;
      b0.in_data  = 8'(8'h40 + (n_acc - base_a));
      step();
    end
    chk("bp_accepted",  128'(n_acc - base_a), 128'(32));
    chk("bp_in_ready",  128'(b0.in_ready), 128'(0));
    chk("bp_slot_valid", 128'(b0.out_valid), 128'(1));
    chk("bp_slot_data", b0.out_data, 128'h404142434445464748494A4B4C4D4E4F);
    chk("bp_no_words",  128'(n_words - base_w), 128'(0));
    b0.out_ready = 1'b1;
    step();
    chk("bp_ready_rises", 128'(b0.in_ready), 128'(1));
    guard = 0;
    while (((n_acc - base_a) < 48 || (n_words - base_w) < 3) && guard < 100) begin
      b0.in_valid = (n_acc - base_a) < 48;
      b0.in_data  = 8'(8'h40 + (n_acc - base_a));
      step();
      guard++;
    end
    b0.in_valid = 1'b0;
    step();
    chk("bp_words", 128'(n_words - base_w), 128'(3));
    chk("bp_q_empty", 128'(exp_q.size()), 128'(0));

    // Drain and close on the same edge
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    for (int i = 0; i < 31; i++) begin
      b0.in_data = (i < 16) ? 8'(8'h80 + i) : 8'(8'h90 + i - 16);
      step();
    end
    base_w = n_words;
    b0.in_data   = 8'h9F;
    b0.out_ready = 1'b1;
    step();
    b0.in_valid = 1'b0;
    #1;
    chk("dc_valid", 128'(b0.out_valid), 128'(1));
    chk("dc_data",  b0.out_data, 128'h909192939495969798999A9B9C9D9E9F);
    chk("dc_count1", 128'(n_words - base_w), 128'(1));
    step();
    chk("dc_count2", 128'(n_words - base_w), 128'(2));
    chk("dc_empty",  128'(b0.out_valid), 128'(0));

    // Reset in the middle of a word
    b0.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b0.in_data = 8'(8'hA0 + i);
      step();
    end
    base_w = n_words;
    b0.in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mrst_valid", 128'(b0.out_valid), 128'(0));
    chk("mrst_data",  b0.out_data, 128'(0));
    chk("mrst_keep",  128'(b0.out_keep), 128'(0));
    chk("mrst_last",  128'(b0.out_last), 128'(0));
    chk("mrst_ready", 128'(b0.in_ready), 128'(0));
    step();
    rst = 1'b0;
    b0.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b0.in_data = 8'(8'hC0 + i);
      step();
    end
    b0.in_valid = 1'b0;
    #1;
    chk("mrst_no_output", 128'(n_words - base_w), 128'(0));
    chk("mrst_word_data", b0.out_data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    chk("mrst_word_keep", 128'(b0.out_keep), 128'hFFFF);
    step();
    chk("mrst_one_word", 128'(n_words - base_w), 128'(1));

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      b0.in_valid  = ($urandom_range(0, 3) != 0);
      b0.flush     = ($urandom_range(0, 7) == 0);
      b0.in_data   = 8'($urandom);
      b0.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b1;
    b0.flush     = 1'b1;
    base_a = n_acc;
    guard  = 0;
    while (n_acc == base_a && guard < 50) begin
      step();
      guard++;
    end
    chk("rand_flush_taken", 128'(n_acc - base_a), 128'(1));
    b0.in_valid = 1'b0;
    b0.flush    = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || b0.out_valid) && guard < 50) begin
      step();
      guard++;
    end
    chk("rand_q_empty", 128'(exp_q.size()), 128'(0));
    chk("rand_idle",    128'(b0.out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
